rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-back arbiter and load scoreboard for the 32x32 integer register file. It shares the register file's single write port among three requesters: the EX stage (single-cycle ALU results), the LSU (load data returning out of order with the pipeline), and the debug port. It also tracks pending load destinations so ID can stall on read-after-write hazards. It sits between EX/LSU/debug and the register file write inputs.

## Interface
- DEPTH, 2 — LSU holding FIFO entries; power of 2, ≥2
- STARVE_LIMIT, 4 — consecutive blocked cycles before the LSU head forces an EX stall (only with RF_WB_STARVE_EN)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ex_we_i  in  1  EX write request
- ex_waddr_i  in  5  EX destination register
- ex_wdata_i  in  32  EX write data
- lsu_valid_i  in  1  LSU load data valid
- lsu_ready_o  out  1  FIFO can accept (count < DEPTH)
- lsu_waddr_i  in  5  load destination register
- lsu_wdata_i  in  32  load data
- dbg_req_i  in  1  debug write request, held until granted
- dbg_gnt_o  out  1  debug write granted this cycle
- dbg_waddr_i  in  5  debug destination register
- dbg_wdata_i  in  32  debug write data
- ld_issue_i  in  1  load issued by ID/EX
- ld_issue_addr_i  in  5  destination register of the issued load
- sb_busy_o  out  32  pending-load bitmap; bit r=1 means register r is awaiting load data
- ex_stall_o  out  1  forces the pipeline to hold EX for one cycle
- rf_we_o  out  1  register file write enable (registered)
- rf_waddr_o  out  5  register file write address (registered)
- rf_wdata_o  out  32  register file write data (registered)

## Operation
- Fixed priority: EX > LSU FIFO head > debug. EX is never backpressured, except through ex_stall_o.
- LSU handshake: an entry is pushed when lsu_valid_i && lsu_ready_o. lsu_ready_o depends only on the registered count, so there is no combinational path from lsu_valid_i. A pop in the same cycle does not raise ready.
- The FIFO head is popped in any cycle where the FIFO is non-empty and EX is not writing.
- Debug is granted only when ex_we_i=0 and the FIFO is empty. dbg_gnt_o is combinational and high for exactly the grant cycle.
- Writes to x0 (address 0) are consumed normally (handshake, pop, grant) but never assert rf_we_o.
- Scoreboard:
  - ld_issue_i sets bit ld_issue_addr_i; address 0 is ignored, so bit 0 is always 0.
  - A popped LSU entry clears its address bit.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - EX and debug writes never touch the scoreboard.
- LSU entries retire in FIFO order; the FIFO pointers wrap modulo DEPTH.
- Reset while active discards FIFO contents, pending grants and the scoreboard; nothing is written after reset.

## Timing
- Reset values: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, sb_busy_o=0, ex_stall_o=0, dbg_gnt_o=0, FIFO empty.
- lsu_ready_o is 0 while rst_n=0 and 1 from the first cycle after release.
- EX request in cycle N → rf_we_o in cycle N+1.
- LSU accepted in cycle N → earliest rf_we_o in cycle N+2 (FIFO register, then output register).
- Debug granted in cycle N → rf_we_o in cycle N+1.
- Scoreboard:
  - A set at edge N is visible on sb_busy_o in N+1.
  - A clear takes effect on the same edge that raises rf_we_o for that load.
- Throughput: one register file write per cycle, and back-to-back writes from any mix of requesters.
- Full FIFO with a simultaneous pop: ready stays 0 that cycle and rises the next cycle.

## Configuration
- RF_WB_STARVE_EN defined:
  - A counter increments each cycle the FIFO is non-empty and blocked by EX, and resets on a pop.
  - When the counter reaches STARVE_LIMIT, ex_stall_o is high for one cycle.
  - In that cycle ex_we_i is ignored (EX holds and re-presents), the head is popped, and the counter resets.
- RF_WB_STARVE_EN undefined: ex_stall_o is tied 0, no counter exists, and the LSU can starve indefinitely under continuous EX writes.

## Test plan
- EX only: ex_we_i=1, waddr=5, wdata=0xDEADBEEF in cycle 1 → rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF in cycle 2; x0 write → rf_we_o stays 0.
- Collision: EX (r3, 0x11) and LSU (r4, 0x22) both valid in cycle 1 → r3 written in cycle 2, r4 written in cycle 3; lsu_ready_o stays 1.
- FIFO full: 3 LSU pushes while EX writes every cycle → ready drops after 2 accepts; third value held by LSU; drain order preserved once EX idles.
- Scoreboard: ld_issue_i for r7 → sb_busy_o[7]=1 next cycle; LSU r7 write → bit clears with rf_we_o; reissue r7 in the clear cycle → bit remains 1.
- Debug: dbg_req_i held with FIFO non-empty → no grant until the FIFO empties and EX is idle; then one gnt pulse and the write occurs the next cycle.
- RF_WB_STARVE_EN with STARVE_LIMIT=4: continuous EX plus one LSU entry → ex_stall_o pulses after 4 blocked cycles and the LSU write lands; reset asserted mid-drain → FIFO empty, sb_busy_o=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Write-back arbiter for the 32x32 integer register file plus a
//            pending-load scoreboard. EX, an LSU holding FIFO and the debug
//            port share the single write port (priority EX > LSU > debug).
// Option   : RF_WB_STARVE_EN - enables the LSU starvation counter that
//            stalls EX for one cycle so a blocked load can retire.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_we_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        dbg_req_i,
    output logic        dbg_gnt_o,
    input  logic [4:0]  dbg_waddr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic        ld_issue_i,
    input  logic [4:0]  ld_issue_addr_i,
    output logic [31:0] sb_busy_o,
    output logic        ex_stall_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o
);

    localparam int               C_AW    = $clog2(DEPTH);
    localparam logic [C_AW:0]    C_DEPTH = (C_AW + 1)'(DEPTH);

    // LSU holding FIFO
    logic [4:0]      r_fifo_addr [DEPTH];
    logic [31:0]     r_fifo_data [DEPTH];
    logic [C_AW-1:0] r_wptr;
    logic [C_AW-1:0] r_rptr;
    logic [C_AW:0]   r_count;

    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_stall;
    logic            w_ex_we;
    logic [4:0]      w_head_addr;
    logic [31:0]     w_head_data;
    logic [31:0]     w_sb_set;
    logic [31:0]     w_sb_clr;

    // Registered write port and scoreboard
    logic            r_rf_we;
    logic [4:0]      r_rf_waddr;
    logic [31:0]     r_rf_wdata;
    logic [31:0]     r_sb_busy;

    assign w_empty     = (r_count == '0);
    assign w_head_addr = r_fifo_addr[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    // Ready looks only at the registered count: a same-cycle pop never
    // raises it, and there is no path from lsu_valid_i.
    assign lsu_ready_o = rst_n && (r_count < C_DEPTH);
    assign w_push      = lsu_valid_i && lsu_ready_o;

    // During a starvation stall EX is held, so its request is ignored.
    assign w_ex_we     = ex_we_i && !w_stall;
    assign w_pop       = !w_empty && !w_ex_we;
    assign dbg_gnt_o   = rst_n && dbg_req_i && !ex_we_i && w_empty;
    assign ex_stall_o  = w_stall;

`ifdef RF_WB_STARVE_EN
    localparam int                C_SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_SW-1:0]   C_LIMIT = C_SW'(STARVE_LIMIT);

    logic [C_SW-1:0] r_starve;

    assign w_stall = !w_empty && (r_starve >= C_LIMIT);

    // Count cycles in which a waiting LSU head loses to EX; any pop clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_pop) begin
            r_starve <= '0;
        end else if (ex_we_i && !w_empty) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    // A legal STARVE_LIMIT is positive, so this is constant 0; it keeps the
    // parameter referenced when the counter is compiled out.
    assign w_stall = (STARVE_LIMIT < 0);
`endif

    // FIFO pointers and occupancy; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= lsu_waddr_i;
            r_fifo_data[r_wptr] <= lsu_wdata_i;
        end
    end

    // Registered write port: EX, then FIFO head, then debug. x0 never writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if (w_ex_we) begin
            r_rf_we    <= (ex_waddr_i != 5'd0);
            r_rf_waddr <= ex_waddr_i;
            r_rf_wdata <= ex_wdata_i;
        end else if (w_pop) begin
            r_rf_we    <= (w_head_addr != 5'd0);
            r_rf_waddr <= w_head_addr;
            r_rf_wdata <= w_head_data;
        end else if (dbg_gnt_o) begin
            r_rf_we    <= (dbg_waddr_i != 5'd0);
            r_rf_waddr <= dbg_waddr_i;
            r_rf_wdata <= dbg_wdata_i;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    assign w_sb_set = (ld_issue_i && (ld_issue_addr_i != 5'd0)) ? (32'd1 << ld_issue_addr_i) : 32'd0;
    assign w_sb_clr = w_pop ? (32'd1 << w_head_addr) : 32'd0;

    // Pending-load bitmap; a set on the same edge as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sb_busy <= '0;
        end else begin
            r_sb_busy <= ((r_sb_busy & ~w_sb_clr) | w_sb_set) & ~32'd1;
        end
    end

    assign rf_we_o    = r_rf_we;
    assign rf_waddr_o = r_rf_waddr;
    assign rf_wdata_o = r_rf_wdata;
    assign sb_busy_o  = r_sb_busy;

endmodule
`default_nettype wire
